// File: rtl/edulent_pkg.sv
// Shared types for the Edulent sequencer: FSM states, opcode constants and
// the opcode classes produced by the decoder.
package edulent_pkg;

  typedef enum logic [4:0] {
    S_RESET, S_FETCH_MA, S_FETCH_RD, S_IR_LD, S_DECODE,
    S_OPND_MA, S_OPND_RD, S_MA_MD, S_MA_AP, S_MA_SP, S_SP_DEC,
    S_DATA_RD, S_MD_A, S_MD_AP, S_DATA_WR, S_WB_A, S_WB_AP,
    S_HALTED, S_TRAP, S_BUS_ERR
  } state_t;

  localparam logic [7:0] OPC_LD_A_DIR  = 8'h11;
  localparam logic [7:0] OPC_LD_AP_DIR = 8'h13;
  localparam logic [7:0] OPC_LD_A_IND  = 8'h14;
  localparam logic [7:0] OPC_LD_A_IMM  = 8'h19;
  localparam logic [7:0] OPC_LD_AP_IMM = 8'h1B;
  localparam logic [7:0] OPC_POP_A     = 8'h1C;
  localparam logic [7:0] OPC_POP_AP    = 8'h1E;
  localparam logic [7:0] OPC_ST_A_DIR  = 8'h21;
  localparam logic [7:0] OPC_ST_AP_DIR = 8'h23;
  localparam logic [7:0] OPC_PUSH_A    = 8'h2C;
  localparam logic [7:0] OPC_PUSH_AP   = 8'h2E;

  typedef enum logic [2:0] {
    CLS_IMM, CLS_DIR_LD, CLS_DIR_ST, CLS_IND, CLS_POP, CLS_PUSH, CLS_HALT, CLS_ILL
  } opc_class_t;

  typedef enum logic {TGT_A, TGT_AP} tgt_t;

endpackage

// File: rtl/seq_control_unit_decoder.sv
// Combinational opcode classifier: instruction class plus target register.
module opcode_decoder
  import edulent_pkg::*;
#(
  parameter int         OPC_W    = 8,
  parameter logic [7:0] HALT_OPC = 8'hFF
) (
  input  logic [OPC_W-1:0] opcode,
  output opc_class_t       cls,
  output tgt_t             tgt
);

  localparam int CW = (OPC_W > 8) ? OPC_W : 8;

  logic [CW-1:0] op;
  assign op = CW'(opcode);

  always_comb begin
    cls = CLS_ILL;
    tgt = TGT_A;
    // HALT wins so a HALT_OPC that collides with a real opcode still halts
    if (op == CW'(HALT_OPC)) begin
      cls = CLS_HALT;
    end else begin
      case (op)
        CW'(OPC_LD_A_IMM):  cls = CLS_IMM;
        CW'(OPC_LD_AP_IMM): begin cls = CLS_IMM;    tgt = TGT_AP; end
        CW'(OPC_LD_A_DIR):  cls = CLS_DIR_LD;
        CW'(OPC_LD_AP_DIR): begin cls = CLS_DIR_LD; tgt = TGT_AP; end
        CW'(OPC_ST_A_DIR):  cls = CLS_DIR_ST;
        CW'(OPC_ST_AP_DIR): begin cls = CLS_DIR_ST; tgt = TGT_AP; end
        CW'(OPC_LD_A_IND):  cls = CLS_IND;
        CW'(OPC_POP_A):     cls = CLS_POP;
        CW'(OPC_POP_AP):    begin cls = CLS_POP;    tgt = TGT_AP; end
        CW'(OPC_PUSH_A):    cls = CLS_PUSH;
        CW'(OPC_PUSH_AP):   begin cls = CLS_PUSH;   tgt = TGT_AP; end
        default:            cls = CLS_ILL;
      endcase
    end
  end

endmodule

// File: rtl/seq_control_unit.sv
// Edulent instruction sequencer: fetch/decode/execute FSM with memory wait
// states, optional bus timeout, HALT and illegal-opcode trap.
module seq_control_unit
  import edulent_pkg::*;
#(
  parameter int         OPC_W           = 8,
  parameter int         WAIT_TIMEOUT    = 0,
  parameter bit         TRAP_ON_ILLEGAL = 1'b1,
  parameter logic [7:0] HALT_OPC        = 8'hFF
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_mem_ready,
  output logic             o_ma_pc,
  output logic             o_ma_md,
  output logic             o_ma_ap,
  output logic             o_ma_sp,
  output logic             o_mem_rd,
  output logic             o_mem_wr,
  output logic             o_pc_inc,
  output logic             o_sp_inc,
  output logic             o_sp_dec,
  output logic             o_ir_ld,
  output logic             o_a_ld,
  output logic             o_ap_ld,
  output logic             o_md_from_a,
  output logic             o_md_from_ap,
  output logic             o_next_instr,
  output logic             o_halted,
  output logic             o_illegal,
  output logic             o_bus_err
);

  localparam int             WCW    = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WC_MAX = '1;
  localparam logic [WCW-1:0] WC_TMO = WCW'(WAIT_TIMEOUT);

  state_t         state;
  opc_class_t     cls_q, dec_cls;
  tgt_t           tgt_q, dec_tgt;
  logic [WCW-1:0] wait_cnt, wait_inc;
  logic           halt_seen, req_st, tmo_hit;

  opcode_decoder #(.OPC_W(OPC_W), .HALT_OPC(HALT_OPC)) u_dec (
    .opcode (i_opcode),
    .cls    (dec_cls),
    .tgt    (dec_tgt)
  );

  assign req_st   = state inside {S_FETCH_RD, S_OPND_RD, S_DATA_RD, S_DATA_WR};
  assign wait_inc = (wait_cnt == WC_MAX) ? wait_cnt : wait_cnt + 1'b1;
  assign tmo_hit  = (WAIT_TIMEOUT > 0) && req_st && !i_mem_ready && (wait_inc == WC_TMO);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_RESET;
      cls_q     <= CLS_ILL;
      tgt_q     <= TGT_A;
      wait_cnt  <= '0;
      halt_seen <= 1'b0;
    end else begin
      wait_cnt  <= (req_st && !i_mem_ready && !tmo_hit) ? wait_inc : '0;
      halt_seen <= (state == S_HALTED);
      case (state)
        S_RESET:    state <= S_FETCH_MA;
        S_FETCH_MA: state <= S_FETCH_RD;
        S_FETCH_RD: if (tmo_hit) state <= S_BUS_ERR;
                    else if (i_mem_ready) state <= S_IR_LD;
        S_IR_LD:    state <= S_DECODE;
        S_DECODE: begin
          // later states branch on this registered copy, never on i_opcode
          cls_q <= dec_cls;
          tgt_q <= dec_tgt;
          case (dec_cls)
            CLS_IMM, CLS_DIR_LD, CLS_DIR_ST: state <= S_OPND_MA;
            CLS_IND:  state <= S_MA_AP;
            CLS_POP:  state <= S_MA_SP;
            CLS_PUSH: state <= S_SP_DEC;
            CLS_HALT: state <= S_HALTED;
            default:  state <= TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH_MA;
          endcase
        end
        S_OPND_MA:  state <= S_OPND_RD;
        S_OPND_RD:  if (tmo_hit) state <= S_BUS_ERR;
                    else if (i_mem_ready)
                      state <= (cls_q != CLS_IMM) ? S_MA_MD :
                               (tgt_q == TGT_AP) ? S_WB_AP : S_WB_A;
        S_MA_MD:    state <= (cls_q == CLS_DIR_LD) ? S_DATA_RD :
                             (tgt_q == TGT_AP) ? S_MD_AP : S_MD_A;
        S_MA_AP:    state <= S_DATA_RD;
        S_SP_DEC:   state <= S_MA_SP;
        S_MA_SP:    state <= (cls_q == CLS_POP) ? S_DATA_RD :
                             (tgt_q == TGT_AP) ? S_MD_AP : S_MD_A;
        S_MD_A, S_MD_AP: state <= S_DATA_WR;
        S_DATA_RD:  if (tmo_hit) state <= S_BUS_ERR;
                    else if (i_mem_ready) state <= (tgt_q == TGT_AP) ? S_WB_AP : S_WB_A;
        S_DATA_WR:  if (tmo_hit) state <= S_BUS_ERR;
                    else if (i_mem_ready) state <= S_FETCH_MA;
        S_WB_A, S_WB_AP: state <= S_FETCH_MA;
        S_HALTED, S_TRAP, S_BUS_ERR: state <= state;
        default:    state <= S_RESET;
      endcase
    end
  end

  // Moore decode; only the pointer steps and the store-completion pulse look at ready
  always_comb begin
    {o_ma_pc, o_ma_md, o_ma_ap, o_ma_sp}   = '0;
    {o_mem_rd, o_mem_wr}                   = '0;
    {o_pc_inc, o_sp_inc, o_sp_dec}         = '0;
    {o_ir_ld, o_a_ld, o_ap_ld}             = '0;
    {o_md_from_a, o_md_from_ap}            = '0;
    {o_next_instr, o_halted, o_illegal, o_bus_err} = '0;
    case (state)
      S_FETCH_MA, S_OPND_MA: o_ma_pc = 1'b1;
      S_FETCH_RD, S_OPND_RD: begin o_mem_rd = 1'b1; o_pc_inc = i_mem_ready; end
      S_IR_LD:   o_ir_ld = 1'b1;
      S_DECODE:  o_next_instr = !TRAP_ON_ILLEGAL && (dec_cls == CLS_ILL);
      S_MA_MD:   o_ma_md = 1'b1;
      S_MA_AP:   o_ma_ap = 1'b1;
      S_MA_SP:   o_ma_sp = 1'b1;
      S_SP_DEC:  o_sp_dec = 1'b1;
      S_DATA_RD: begin o_mem_rd = 1'b1; o_sp_inc = i_mem_ready && (cls_q == CLS_POP); end
      S_MD_A:    o_md_from_a = 1'b1;
      S_MD_AP:   o_md_from_ap = 1'b1;
      S_DATA_WR: begin o_mem_wr = 1'b1; o_next_instr = i_mem_ready; end
      S_WB_A:    begin o_a_ld = 1'b1; o_next_instr = 1'b1; end
      S_WB_AP:   begin o_ap_ld = 1'b1; o_next_instr = 1'b1; end
      S_HALTED:  begin o_halted = 1'b1; o_next_instr = !halt_seen; end
      S_TRAP:    o_illegal = 1'b1;
      S_BUS_ERR: o_bus_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit: three instances (default, illegal-as-NOP,
// 4-cycle timeout) driven from a cycle-by-cycle vector table.
module tb_seq_control_unit;

  localparam logic [17:0] MPC = 18'h20000, MMD = 18'h10000, MAP = 18'h08000, MSP = 18'h04000;
  localparam logic [17:0] RD  = 18'h02000, WR  = 18'h01000, PCI = 18'h00800, SPI = 18'h00400;
  localparam logic [17:0] SPD = 18'h00200, IRL = 18'h00100, ALD = 18'h00080, APL = 18'h00040;
  localparam logic [17:0] MDA = 18'h00020, MDP = 18'h00010, NXT = 18'h00008, HLT = 18'h00004;
  localparam logic [17:0] ILL = 18'h00002, BER = 18'h00001;

  typedef struct {
    int          inst;
    logic        rst;
    logic [7:0]  opc;
    logic        rdy;
    logic [17:0] exp;
    string       nm;
  } vec_t;

  logic       clk = 1'b0;
  logic [2:0] rstn = 3'b000;
  logic [7:0] opc = 8'h00;
  logic       rdy = 1'b0;
  logic [2:0] ma_pc, ma_md, ma_ap, ma_sp, mem_rd, mem_wr, pc_inc, sp_inc, sp_dec;
  logic [2:0] ir_ld, a_ld, ap_ld, md_a, md_ap, nxt, halted, illegal, bus_err;

  int   checks = 0;
  int   errors = 0;
  vec_t q[$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    seq_control_unit #(
      .OPC_W(8), .WAIT_TIMEOUT((k == 2) ? 4 : 0),
      .TRAP_ON_ILLEGAL(k != 1), .HALT_OPC(8'hFF)
    ) u_dut (
      .i_clk(clk), .i_rstn(rstn[k]), .i_opcode(opc), .i_mem_ready(rdy),
      .o_ma_pc(ma_pc[k]), .o_ma_md(ma_md[k]), .o_ma_ap(ma_ap[k]), .o_ma_sp(ma_sp[k]),
      .o_mem_rd(mem_rd[k]), .o_mem_wr(mem_wr[k]),
      .o_pc_inc(pc_inc[k]), .o_sp_inc(sp_inc[k]), .o_sp_dec(sp_dec[k]),
      .o_ir_ld(ir_ld[k]), .o_a_ld(a_ld[k]), .o_ap_ld(ap_ld[k]),
      .o_md_from_a(md_a[k]), .o_md_from_ap(md_ap[k]), .o_next_instr(nxt[k]),
      .o_halted(halted[k]), .o_illegal(illegal[k]), .o_bus_err(bus_err[k])
    );
  end

  function automatic logic [17:0] outw(int k);
    return {ma_pc[k], ma_md[k], ma_ap[k], ma_sp[k], mem_rd[k], mem_wr[k], pc_inc[k],
            sp_inc[k], sp_dec[k], ir_ld[k], a_ld[k], ap_ld[k], md_a[k], md_ap[k],
            nxt[k], halted[k], illegal[k], bus_err[k]};
  endfunction

  task automatic chk(string nm, logic [17:0] act, logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(int inst, logic rst, logic [7:0] o, logic r, logic [17:0] e, string nm);
    vec_t v;
    v.inst = inst; v.rst = rst; v.opc = o; v.rdy = r; v.exp = e; v.nm = nm;
    q.push_back(v);
  endtask

  task automatic fetch(int inst, logic [7:0] o);
    add(inst, 1, o, 1, MPC,      "fetch_ma");
    add(inst, 1, o, 1, RD | PCI, "fetch_rd");
    add(inst, 1, o, 1, IRL,      "ir_ld");
  endtask

  // drive on the falling edge, sample 1 ns later; non-selected instances sit in reset
  task automatic apply(vec_t v);
    logic [2:0] r;
    r = 3'b000;
    r[v.inst] = v.rst;
    @(negedge clk);
    rstn = r; opc = v.opc; rdy = v.rdy;
    #1;
    chk(v.nm, outw(v.inst), v.exp);
  endtask

  task automatic run_all();
    foreach (q[i]) apply(q[i]);
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    // immediate load, zero wait: next_instr on the 7th cycle counting FETCH_MA as 1
    add(0, 0, 8'h19, 1, '0, "reset_held");
    add(0, 1, 8'h19, 1, '0, "reset_state");
    fetch(0, 8'h19);
    add(0, 1, 8'h19, 1, '0,        "imm_decode");
    add(0, 1, 8'h19, 1, MPC,       "imm_opnd_ma");
    add(0, 1, 8'h19, 1, RD | PCI,  "imm_opnd_rd");
    add(0, 1, 8'h19, 1, ALD | NXT, "imm_wb_a");
    // direct load with 3 wait cycles in DATA_RD; IR changes mid-wait are ignored
    fetch(0, 8'h11);
    add(0, 1, 8'h11, 1, '0,        "ld_decode");
    add(0, 1, 8'h11, 1, MPC,       "ld_opnd_ma");
    add(0, 1, 8'h11, 1, RD | PCI,  "ld_opnd_rd");
    add(0, 1, 8'h11, 1, MMD,       "ld_ma_md");
    add(0, 1, 8'h55, 0, RD,        "ld_wait1");
    add(0, 1, 8'h2C, 0, RD,        "ld_wait2");
    add(0, 1, 8'hFF, 0, RD,        "ld_wait3");
    add(0, 1, 8'h13, 1, RD,        "ld_data_rd");
    add(0, 1, 8'h13, 1, ALD | NXT, "ld_wb_a");
    // push A with a wait in fetch and in the write
    add(0, 1, 8'h2C, 1, MPC,       "push_fetch_ma");
    add(0, 1, 8'h2C, 0, RD,        "push_fetch_wait");
    add(0, 1, 8'h2C, 1, RD | PCI,  "push_fetch_rd");
    add(0, 1, 8'h2C, 1, IRL,       "push_ir_ld");
    add(0, 1, 8'h2C, 1, '0,        "push_decode");
    add(0, 1, 8'h2C, 1, SPD,       "push_sp_dec");
    add(0, 1, 8'h2C, 1, MSP,       "push_ma_sp");
    add(0, 1, 8'h2C, 1, MDA,       "push_md_a");
    add(0, 1, 8'h2C, 0, WR,        "push_wr_wait");
    add(0, 1, 8'h2C, 1, WR | NXT,  "push_wr_done");
    // pop AP
    fetch(0, 8'h1E);
    add(0, 1, 8'h1E, 1, '0,        "pop_decode");
    add(0, 1, 8'h1E, 1, MSP,       "pop_ma_sp");
    add(0, 1, 8'h1E, 0, RD,        "pop_rd_wait");
    add(0, 1, 8'h1E, 1, RD | SPI,  "pop_rd_done");
    add(0, 1, 8'h1E, 1, APL | NXT, "pop_wb_ap");
    // store AP direct, operand fetch waits once
    fetch(0, 8'h23);
    add(0, 1, 8'h23, 1, '0,        "st_decode");
    add(0, 1, 8'h23, 1, MPC,       "st_opnd_ma");
    add(0, 1, 8'h23, 0, RD,        "st_opnd_wait");
    add(0, 1, 8'h23, 1, RD | PCI,  "st_opnd_rd");
    add(0, 1, 8'h23, 1, MMD,       "st_ma_md");
    add(0, 1, 8'h23, 1, MDP,       "st_md_ap");
    add(0, 1, 8'h23, 1, WR | NXT,  "st_wr");
    // load indirect
    fetch(0, 8'h14);
    add(0, 1, 8'h14, 1, '0,        "ind_decode");
    add(0, 1, 8'h14, 1, MAP,       "ind_ma_ap");
    add(0, 1, 8'h14, 1, RD,        "ind_rd");
    add(0, 1, 8'h14, 1, ALD | NXT, "ind_wb_a");
    // halt: one next_instr pulse, then halted regardless of inputs
    fetch(0, 8'hFF);
    add(0, 1, 8'hFF, 1, '0,        "halt_decode");
    add(0, 1, 8'hFF, 1, HLT | NXT, "halt_entry");
    add(0, 1, 8'h19, 0, HLT,       "halt_hold1");
    add(0, 1, 8'h11, 1, HLT,       "halt_hold2");
    // reset clears halt; illegal opcode traps
    add(0, 0, 8'h55, 1, '0,        "halt_reset");
    add(0, 1, 8'h55, 1, '0,        "reset_state2");
    fetch(0, 8'h55);
    add(0, 1, 8'h55, 1, '0,        "ill_decode");
    add(0, 1, 8'h55, 1, ILL,       "ill_trap");
    run_all();

    // trap holds with no further strobes for 20 cycles
    for (int i = 0; i < 20; i++) begin
      v.inst = 0; v.rst = 1; v.opc = 8'(i * 13); v.rdy = i[0]; v.exp = ILL; v.nm = "trap_hold";
      apply(v);
    end

    // illegal executes as NOP when trapping is disabled
    add(1, 0, 8'h55, 1, '0,        "nop_reset");
    add(1, 1, 8'h55, 1, '0,        "nop_reset_state");
    fetch(1, 8'h55);
    add(1, 1, 8'h55, 1, NXT,       "nop_decode");
    add(1, 1, 8'h19, 1, MPC,       "nop_refetch_ma");
    add(1, 1, 8'h19, 1, RD | PCI,  "nop_refetch_rd");
    // bus timeout of 4 in FETCH_RD; error is sticky even if ready arrives
    add(2, 0, 8'h19, 0, '0,        "tmo_reset");
    add(2, 1, 8'h19, 0, '0,        "tmo_reset_state");
    add(2, 1, 8'h19, 0, MPC,       "tmo_fetch_ma");
    add(2, 1, 8'h19, 0, RD,        "tmo_wait1");
    add(2, 1, 8'h19, 0, RD,        "tmo_wait2");
    add(2, 1, 8'h19, 0, RD,        "tmo_wait3");
    add(2, 1, 8'h19, 0, RD,        "tmo_wait4");
    add(2, 1, 8'h19, 0, BER,       "tmo_bus_err");
    add(2, 1, 8'h19, 1, BER,       "tmo_sticky1");
    add(2, 1, 8'h19, 1, BER,       "tmo_sticky2");
    // push AP on the default instance, long write wait (no timeout configured)
    add(0, 0, 8'h2E, 1, '0,        "push2_reset");
    add(0, 1, 8'h2E, 1, '0,        "push2_reset_state");
    fetch(0, 8'h2E);
    add(0, 1, 8'h2E, 1, '0,        "push2_decode");
    add(0, 1, 8'h2E, 1, SPD,       "push2_sp_dec");
    add(0, 1, 8'h2E, 1, MSP,       "push2_ma_sp");
    add(0, 1, 8'h2E, 1, MDP,       "push2_md_ap");
    for (int i = 0; i < 6; i++) add(0, 1, 8'h2E, 0, WR, "push2_wr_wait");
    run_all();

    // async reset between edges drops the write immediately
    #2;
    rstn = 3'b000;
    #1;
    chk("async_wr_drop", {17'b0, mem_wr[0]}, '0);
    chk("async_all_low", outw(0), '0);
    add(0, 0, 8'h2E, 1, '0,        "async_held");
    add(0, 1, 8'h2E, 1, '0,        "async_first_reset");
    add(0, 1, 8'h2E, 1, MPC,       "async_then_fetch");
    run_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
